// File: rtl/alu_tx_pkg.sv
// rtl/alu_tx_pkg.sv - shared types for the ALU result UART logger (ALU_TX_PARITY_EN adds PARITY state)
package alu_tx_pkg;

  localparam int ENTRY_W = 15;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] flags;
    logic [7:0] res;
  } entry_t;

`ifdef ALU_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  // Second UART byte: flags in the high nibble, bit 3 reserved as zero, op code low.
  function automatic logic [7:0] pack_byte1(input logic [3:0] flags, input logic [2:0] op);
    return {flags, 1'b0, op};
  endfunction

endpackage

// File: rtl/alu_tx_fifo.sv
// rtl/alu_tx_fifo.sv - synchronous snapshot FIFO; a push while full is accepted when a pop frees the slot
module alu_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_uart_tx.sv
// rtl/alu_result_uart_tx.sv - ALU snapshot capture, FIFO and two-byte UART transmitter (ALU_TX_PARITY_EN: even parity bit)
module alu_result_uart_tx
  import alu_tx_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          capture,
  input  logic [7:0]                    res_in,
  input  logic [3:0]                    flags_in,
  input  logic [2:0]                    op_in,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_cnt
);

  localparam int BAUD_W = $clog2(CLK_DIV);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic              byte_sel;
  logic [15:0]       hold;
  entry_t            wr_entry;
  entry_t            rd_entry;
  logic              push_req;
  logic              pop;
  logic              fifo_empty;
  logic              baud_end;
  logic [7:0]        cur_byte;

  assign push_req = capture & ena;
  assign pop      = (state == IDLE) & ~fifo_empty;
  assign wr_entry = {op_in, flags_in, res_in};
  assign baud_end = (baud == BAUD_W'(CLK_DIV - 1));
  assign cur_byte = byte_sel ? hold[15:8] : hold[7:0];
  assign busy     = (state != IDLE) | (fifo_count != '0);

  alu_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (pop) state_nxt = START;
      START:  if (baud_end) state_nxt = DATA;
`ifdef ALU_TX_PARITY_EN
      DATA:   if (baud_end && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY: if (baud_end) state_nxt = STOP;
`else
      DATA:   if (baud_end && bit_idx == 3'd7) state_nxt = STOP;
`endif
      // byte1 follows byte0 without returning to IDLE
      STOP:   if (baud_end) state_nxt = byte_sel ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:  tx = 1'b0;
      DATA:   tx = cur_byte[bit_idx];
`ifdef ALU_TX_PARITY_EN
      PARITY: tx = ^cur_byte;
`endif
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud     <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      hold     <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == IDLE || baud_end) baud <= '0;
      else                           baud <= baud + BAUD_W'(1);

      if (state != DATA)  bit_idx <= '0;
      else if (baud_end)  bit_idx <= bit_idx + 3'd1;

      if (pop) begin
        byte_sel <= 1'b0;
        hold     <= {pack_byte1(rd_entry.flags, rd_entry.op), rd_entry.res};
      end else if (state == STOP && baud_end) begin
        byte_sel <= 1'b1;
      end

      // A capture while full is only lost if no pop frees a slot this cycle.
      if (push_req && fifo_full && !pop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// tb/tb_alu_result_uart_tx.sv - randomized model-checked bench for alu_result_uart_tx
module tb_alu_result_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef ALU_TX_PARITY_EN
  localparam int BYTE_BITS = 11;
`else
  localparam int BYTE_BITS = 10;
`endif
  localparam int FRAME_BITS = 2 * BYTE_BITS;
  localparam int FRAME_LEN  = FRAME_BITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       capture = 1'b0;
  logic [7:0] res_in = '0;
  logic [3:0] flags_in = '0;
  logic [2:0] op_in = '0;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [14:0] m_q[$];
  bit          m_valid = 0;
  bit          m_active = 0;
  int          m_t = 0;
  int          m_drop = 0;
  bit          m_frame[FRAME_BITS];

  alu_result_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .capture    (capture),
    .res_in     (res_in),
    .flags_in   (flags_in),
    .op_in      (op_in),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_frame(input logic [14:0] e);
    logic [7:0] b [2];
    int k;
    b[0] = e[7:0];
    b[1] = {e[11:8], 1'b0, e[14:12]};
    k = 0;
    for (int j = 0; j < 2; j++) begin
      m_frame[k] = 1'b0; k = k + 1;
      for (int i = 0; i < 8; i++) begin
        m_frame[k] = b[j][i]; k = k + 1;
      end
`ifdef ALU_TX_PARITY_EN
      m_frame[k] = ^b[j]; k = k + 1;
`endif
      m_frame[k] = 1'b1; k = k + 1;
    end
  endtask

  task automatic model_step();
    int sz;
    bit do_pop;
    if (!rst_n) begin
      m_q.delete();
      m_active = 0;
      m_t = 0;
      m_drop = 0;
      m_valid = 1;
    end else if (m_valid) begin
      sz = m_q.size();
      do_pop = !m_active && sz > 0;
      if (m_active) begin
        m_t++;
        if (m_t == FRAME_LEN) m_active = 0;
      end
      if (do_pop) begin
        build_frame(m_q.pop_front());
        m_active = 1;
        m_t = 0;
      end
      if (capture && ena) begin
        if (sz < DEPTH || do_pop) m_q.push_back({op_in, flags_in, res_in});
        else if (m_drop < 255) m_drop++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("m_tx", tx, m_active ? m_frame[m_t / CLK_DIV] : 1'b1);
      chk("m_busy", busy, (m_active || m_q.size() > 0));
      chk("m_count", fifo_count, m_q.size());
      chk("m_full", fifo_full, m_q.size() == DEPTH);
      chk("m_drop", drop_cnt, m_drop);
    end
  end

  task automatic wait_start();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx === 1'b0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("start_seen", ok, 1'b1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef ALU_TX_PARITY_EN
  logic [0:21] lit = 22'b0_10100101_0_1_0_01001001_1_1;
`else
  logic [0:19] lit = 20'b0_10100101_1_0_01001001_1;
`endif

  initial begin
    int lows;
    rst_n = 1'b0;
    capture = 1'b1;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_drop", drop_cnt, 8'd0);
    rst_n = 1'b1;
    capture = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_tx", tx, 1'b1);

    res_in = 8'hA5; flags_in = 4'b1001; op_in = 3'd2; capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    wait_start();
    for (int i = 0; i < FRAME_LEN; i++) begin
      chk("frame_lit", tx, lit[i / CLK_DIV]);
      @(negedge clk);
    end
    chk("busy_after", busy, 1'b0);

    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      res_in = 8'($urandom); flags_in = 4'($urandom); op_in = 3'($urandom);
      capture = 1'b1;
      @(negedge clk);
    end
    capture = 1'b0;
    chk("ovf_drop", drop_cnt, 8'd1);
    chk("ovf_full", fifo_full, 1'b1);
    chk("ovf_count", fifo_count, 3'd4);

    capture = 1'b1;
    repeat (300) @(negedge clk);
    capture = 1'b0;
    @(negedge clk);
    chk("sat_drop", drop_cnt, 8'd255);

    pulse_reset();
    ena = 1'b0; capture = 1'b1;
    @(negedge clk);
    capture = 1'b0; ena = 1'b1;
    @(negedge clk);
    chk("ena_count", fifo_count, 3'd0);
    chk("ena_busy", busy, 1'b0);

    res_in = 8'h3C; capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    wait_start();
    repeat (CLK_DIV + 2 * CLK_DIV + 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_count", fifo_count, 3'd0);
    chk("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    lows = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    chk("midrst_quiet", lows, 0);

    for (int i = 0; i < 3000; i++) begin
      capture  = ($urandom_range(0, 24) == 0);
      ena      = ($urandom_range(0, 7) != 0);
      rst_n    = ($urandom_range(0, 1999) != 0);
      res_in   = 8'($urandom);
      flags_in = 4'($urandom);
      op_in    = 3'($urandom);
      @(negedge clk);
    end
    capture = 1'b0; rst_n = 1'b1; ena = 1'b1;
    repeat (FRAME_LEN * (DEPTH + 2)) @(negedge clk);
    chk("drain_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
